dm_arbiter: RTL

- Shares the single-port synchronous data memory between two requesters: port 0 is the CPU M-stage data port, port 1 is an auxiliary master (DMA/debug loader).
- Per access, it arbitrates, generates byte-write enables for SW/SH/SB, and sign- or zero-extends LW/LH/LHU/LB/LBU read data.
- It flags misaligned and out-of-range accesses as errors and never touches memory for them.
- Sits between the M stage / aux master and the DM RAM; CPU stall logic keys off p0_ack.

---
 rtl/dm_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one single-port synchronous data RAM between the CPU
// M-stage port (port 0) and an auxiliary master (port 1). Each access runs
// IDLE -> ACC -> RESP (legal) or IDLE -> RESP (misaligned/out of range).
// Define DM_ARB_CPU_PRIORITY_EN for fixed priority to port 0; otherwise
// contending requests are served round-robin.
module dm_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic [2:0]        p0_op,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [31:0]       p0_rdata,
  input  logic              p1_req,
  input  logic [2:0]        p1_op,
  input  logic [31:0]       p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [31:0]       p1_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t               state, state_nx;
  logic                 owner;
  logic [2:0]           op_q;
  logic [ADDR_W+1:0]    addr_q;
  logic [31:0]          wdata_q;
  logic                 err_q;

  logic                 win;
  logic [2:0]           sel_op;
  logic [31:0]          sel_addr;
  logic [31:0]          sel_wdata;
  logic                 sel_bad;
  logic [31:0]          resp_data;

  function automatic logic is_illegal(input logic [2:0] op, input logic [31:0] a);
    logic bad;
    bad = ((a >> (ADDR_W + 2)) != 32'd0);
    case (op)
      OP_LW, OP_SW:         bad = bad | (a[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: bad = bad | a[0];
      default:              bad = bad;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_SW:   return 4'b1111;
      OP_SH:   return a[1] ? 4'b1100 : 4'b0011;
      OP_SB:   return 4'b0001 << a;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] op, input logic [31:0] w);
    case (op)
      OP_SW:   return w;
      OP_SH:   return {2{w[15:0]}};
      OP_SB:   return {4{w[7:0]}};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LW:   return w;
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'd0, h};
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'd0, b};
      default: return 32'd0;
    endcase
  endfunction

`ifdef DM_ARB_CPU_PRIORITY_EN
  // Fixed priority: port 0 wins whenever it requests.
  always_comb begin
    win = ~p0_req;
  end
`else
  logic rr;

  // Round-robin: on contention the pointer decides, otherwise the lone requester wins.
  always_comb begin
    win = (p0_req && p1_req) ? rr : p1_req;
  end

  // Pointer names the port that wins the next contention; it flips on every grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr <= 1'b0;
    else if (state == IDLE && (p0_req || p1_req))
      rr <= ~win;
  end
`endif

  // Winner's request fields and their legality.
  always_comb begin
    sel_op    = win ? p1_op    : p0_op;
    sel_addr  = win ? p1_addr  : p0_addr;
    sel_wdata = win ? p1_wdata : p0_wdata;
    sel_bad   = is_illegal(sel_op, sel_addr);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Latch the granted request so the requester's inputs need not be used after grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner   <= 1'b0;
      op_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (state == IDLE && (p0_req || p1_req)) begin
      owner   <= win;
      op_q    <= sel_op;
      addr_q  <= sel_addr[ADDR_W+1:0];
      wdata_q <= sel_wdata;
      err_q   <= sel_bad;
    end
  end

  // Next state plus all outputs; everything is 0 outside its own state.
  always_comb begin
    state_nx  = state;
    mem_en    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    p0_ack    = 1'b0;
    p0_err    = 1'b0;
    p0_rdata  = 32'd0;
    p1_ack    = 1'b0;
    p1_err    = 1'b0;
    p1_rdata  = 32'd0;
    resp_data = err_q ? 32'd0 : load_ext(op_q, addr_q[1:0], mem_rdata);
    case (state)
      IDLE: begin
        if (p0_req || p1_req)
          state_nx = sel_bad ? RESP : ACC;
      end
      ACC: begin
        mem_en    = 1'b1;
        mem_be    = byte_en(op_q, addr_q[1:0]);
        mem_addr  = addr_q[ADDR_W+1:2];
        mem_wdata = lane_data(op_q, wdata_q);
        state_nx  = RESP;
      end
      RESP: begin
        if (owner) begin
          p1_ack   = 1'b1;
          p1_err   = err_q;
          p1_rdata = resp_data;
        end else begin
          p0_ack   = 1'b1;
          p0_err   = err_q;
          p0_rdata = resp_data;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
